imem_prog: RTL and testbench

Programmable instruction memory for the single-cycle RISC-V core. It replaces hard-coded instruction tables with a RAM that a loader fills one 32-bit word per handshake, then serves registered instruction fetches. Fetches are checked for misalignment and out-of-range addresses. It sits between the testbench or boot loader and the core's fetch stage, and holds the core stalled until a program has been loaded and released.

---
 rtl/imem_prog.sv | 137 +++++++++++++
 tb/tb_imem_prog.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_prog.sv
// imem_prog: programmable instruction memory for the single-cycle RISC-V core.
// A loader streams 32-bit words in through a valid/ready handshake. Once the
// last word is accepted, or when go releases it without loading, the core may
// fetch. Fetch data is registered and returned one cycle after the request.
// Misaligned and out-of-range fetches return NOP and raise fault. The core is
// held stalled in every state except RUN.
//
// Ports:
//   clk, rst            rising-edge clock; synchronous active-low reset
//   ld_start            pulse: enter LOAD and clear the write pointer
//   ld_valid/ld_ready   loader handshake; ld_ready is high throughout LOAD
//   ld_data, ld_last    word to store; ld_last marks the final word
//   ld_count            words written since the last ld_start (0..DEPTH)
//   ld_err              sticky: a word arrived while the memory was full
//   go                  pulse: leave IDLE for RUN without loading
//   stall               core must hold its PC
//   fetch_req, A        fetch request and its byte address
//   RD, rd_valid, fault registered fetch result, one cycle after fetch_req
module imem_prog #(
  parameter int          DEPTH = 512,
  parameter logic [31:0] NOP   = 32'h00000013,
  localparam int         IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_start,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  output logic [IW:0]   ld_count,
  output logic          ld_err,
  input  logic          go,
  output logic          stall,
  input  logic          fetch_req,
  input  logic [31:0]   A,
  output logic [31:0]   RD,
  output logic          rd_valid,
  output logic          fault
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]  state;
  logic [IW:0] ptr;

  // Words are stored XORed with NOP. A zero-initialised array therefore reads
  // back as NOP without any clear sequence, and reset can leave memory alone.
  logic [31:0] mem [DEPTH];

  // DEPTH is a power of two and ptr never exceeds DEPTH, so the MSB alone
  // marks a full memory.
  logic full, beat, we;
  assign full = ptr[IW];
  // A beat in the same cycle as ld_start is discarded by the restart.
  assign beat = (state == S_LOAD) && !ld_start && ld_valid;
  assign we   = beat && !full;

  assign ld_ready = (state == S_LOAD);
  assign stall    = (state != S_RUN);
  assign ld_count = ptr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      ptr    <= '0;
      ld_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ld_start) begin
            state  <= S_LOAD;
            ptr    <= '0;
            ld_err <= 1'b0;
          end else if (go) begin
            state <= S_RUN;
          end
        end
        S_LOAD: begin
          if (ld_start) begin
            ptr    <= '0;
            ld_err <= 1'b0;
          end else if (ld_valid) begin
            // A full memory drops the word but still honours ld_last, so an
            // oversized program cannot wedge the core in LOAD.
            if (full) ld_err <= 1'b1;
            else      ptr    <= ptr + {{IW{1'b0}}, 1'b1};
            if (ld_last) state <= S_RUN;
          end
        end
        S_RUN: begin
          if (ld_start) begin
            state  <= S_LOAD;
            ptr    <= '0;
            ld_err <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[ptr[IW-1:0]] <= ld_data ^ NOP;
  end

  // Fetch decode. The request is qualified by the current state, so a fetch
  // issued alongside ld_start in RUN still completes.
  logic [IW-1:0] idx;
  logic          oor, mis, fire;
  assign idx  = A[IW+1:2];
  assign oor  = |A[31:IW+2];
  assign mis  = |A[1:0];
  assign fire = fetch_req && (state == S_RUN);

  always_ff @(posedge clk) begin
    if (!rst) begin
      RD       <= NOP;
      fault    <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= fire;
      if (fire) begin
        if (oor || mis) begin
          RD    <= NOP;
          fault <= 1'b1;
        end else begin
          RD    <= mem[idx] ^ NOP;
          fault <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_prog.sv
module tb_imem_prog;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [31:0] rd;
    logic        flt;
  } exp_t;

  logic clk, rst;
  // DEPTH=512 instance
  logic        ld_start, ld_valid, ld_last, go, fetch_req;
  logic [31:0] ld_data, A;
  logic        ld_ready, ld_err, stall, rd_valid, fault;
  logic [9:0]  ld_count;
  logic [31:0] RD;
  // DEPTH=4 instance
  logic        b_ld_start, b_ld_valid, b_ld_last, b_go, b_fetch_req;
  logic [31:0] b_ld_data, b_A;
  logic        b_ld_ready, b_ld_err, b_stall, b_rd_valid, b_fault;
  logic [2:0]  b_ld_count;
  logic [31:0] b_RD;

  imem_prog #(.DEPTH(512)) u0 (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .ld_count(ld_count), .ld_err(ld_err), .go(go), .stall(stall),
    .fetch_req(fetch_req), .A(A), .RD(RD), .rd_valid(rd_valid), .fault(fault));

  imem_prog #(.DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .ld_start(b_ld_start), .ld_valid(b_ld_valid),
    .ld_ready(b_ld_ready), .ld_data(b_ld_data), .ld_last(b_ld_last),
    .ld_count(b_ld_count), .ld_err(b_ld_err), .go(b_go), .stall(b_stall),
    .fetch_req(b_fetch_req), .A(b_A), .RD(b_RD), .rd_valid(b_rd_valid),
    .fault(b_fault));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t q[$];
  logic [31:0] m0 [512];
  logic [31:0] m4 [4];
  logic [31:0] w [4];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour of a RUN-state fetch on the 512-word instance.
  function automatic exp_t model0(input logic [31:0] a);
    exp_t e;
    if (a[1:0] != 2'b0 || a[31:11] != 21'b0) begin
      e.rd = NOP; e.flt = 1'b1;
    end else begin
      e.rd = m0[a[10:2]]; e.flt = 1'b0;
    end
    return e;
  endfunction

  task automatic test_reset;
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL reset_stall got %b exp 1", stall); end
    n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ld_ready got %b exp 0", ld_ready); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    n_cmp++; if (RD !== NOP) begin n_bad++; $display("FAIL reset_RD got %h exp %h", RD, NOP); end
    n_cmp++; if (ld_count !== 10'd0 || ld_err !== 1'b0 || fault !== 1'b0) begin
      n_bad++; $display("FAIL reset_count_err got %0d/%b/%b exp 0/0/0", ld_count, ld_err, fault); end
    n_cmp++; if (b_stall !== 1'b1 || b_ld_count !== 3'd0) begin
      n_bad++; $display("FAIL reset_b got stall %b cnt %0d exp 1/0", b_stall, b_ld_count); end
    // fetches are ignored in IDLE
    fetch_req = 1'b1; A = 32'd0;
    tick();
    fetch_req = 1'b0;
    n_cmp++; if (rd_valid !== 1'b0 || RD !== NOP) begin
      n_bad++; $display("FAIL idle_fetch got v=%b RD=%h exp v=0 RD=%h", rd_valid, RD, NOP); end
  endtask

  task automatic test_load_fetch;
    logic [31:0] addrs [4];
    exp_t e;
    addrs[0] = 32'd0; addrs[1] = 32'd4; addrs[2] = 32'd8; addrs[3] = 32'd12;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    n_cmp++; if (ld_ready !== 1'b1 || stall !== 1'b1 || ld_count !== 10'd0) begin
      n_bad++; $display("FAIL load_entry got rdy %b stall %b cnt %0d exp 1/1/0", ld_ready, stall, ld_count); end
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = w[i]; ld_last = (i == 3);
      m0[i] = w[i];
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    n_cmp++; if (ld_count !== 10'd4 || stall !== 1'b0 || ld_ready !== 1'b0) begin
      n_bad++; $display("FAIL load_done got cnt %0d stall %b rdy %b exp 4/0/0", ld_count, stall, ld_ready); end
    for (int i = 0; i < 4; i++) begin
      fetch_req = 1'b1; A = addrs[i];
      q.push_back(model0(A));
      tick();
      n_cmp++;
      if (rd_valid !== 1'b1) begin
        n_bad++; $display("FAIL fetch_valid[%0d] got %b exp 1", i, rd_valid);
      end else begin
        e = q.pop_front();
        if (RD !== e.rd || fault !== e.flt) begin
          n_bad++; $display("FAIL fetch[%0d] got %h/%b exp %h/%b", i, RD, fault, e.rd, e.flt); end
      end
    end
    fetch_req = 1'b0;
    tick();
    n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL fetch_pulse got %b exp 0", rd_valid); end
    q.delete();
  endtask

  task automatic test_faults;
    logic [31:0] addrs [4];
    exp_t e;
    addrs[0] = 32'd6; addrs[1] = 32'd2048; addrs[2] = 32'd0; addrs[3] = 32'h8000_0004;
    for (int i = 0; i < 4; i++) begin
      fetch_req = 1'b1; A = addrs[i];
      q.push_back(model0(A));
      tick();
      n_cmp++;
      if (rd_valid !== 1'b1) begin
        n_bad++; $display("FAIL fault_valid[%0d] got %b exp 1", i, rd_valid);
      end else begin
        e = q.pop_front();
        if (RD !== e.rd || fault !== e.flt) begin
          n_bad++; $display("FAIL fault[%0d] A=%h got %h/%b exp %h/%b", i, addrs[i], RD, fault, e.rd, e.flt); end
      end
    end
    fetch_req = 1'b0;
    q.delete();
  endtask

  task automatic test_gaps;
    logic [31:0] addrs [4];
    logic [3:0]  v;
    exp_t e;
    int p;
    addrs[0] = 32'd0; addrs[1] = 32'd4; addrs[2] = 32'd8; addrs[3] = 32'd12;
    v = 4'b1101; // ld_valid 1,0,1,1 from bit 0 upward
    // RUN -> LOAD with a concurrent fetch, which must still complete
    ld_start = 1'b1; fetch_req = 1'b1; A = 32'd4;
    q.push_back(model0(A));
    tick();
    ld_start = 1'b0; A = 32'd0;
    e = q.pop_front();
    n_cmp++; if (rd_valid !== 1'b1 || RD !== e.rd || stall !== 1'b1) begin
      n_bad++; $display("FAIL reload_fetch got v %b RD %h stall %b exp 1/%h/1", rd_valid, RD, stall, e.rd); end
    p = 0;
    for (int i = 0; i < 4; i++) begin
      ld_valid = v[i]; ld_data = 32'hA000_0000 + i;
      if (v[i]) begin m0[p] = ld_data; p++; end
      tick();
      n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL load_fetch_ignored[%0d] got %b exp 0", i, rd_valid); end
    end
    fetch_req = 1'b0; ld_valid = 1'b0;
    n_cmp++; if (ld_count !== 10'd3 || RD !== e.rd) begin
      n_bad++; $display("FAIL gap_count got %0d RD %h exp 3 %h", ld_count, RD, e.rd); end
    // restart mid-load; the concurrent beat (even with ld_last) is discarded
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF; ld_last = 1'b1;
    tick();
    ld_start = 1'b0;
    n_cmp++; if (ld_count !== 10'd0 || stall !== 1'b1 || ld_err !== 1'b0) begin
      n_bad++; $display("FAIL restart got cnt %0d stall %b err %b exp 0/1/0", ld_count, stall, ld_err); end
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_data = 32'hB000_0000 + i; ld_last = (i == 1);
      m0[i] = ld_data;
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    n_cmp++; if (ld_count !== 10'd2 || stall !== 1'b0) begin
      n_bad++; $display("FAIL reload_done got cnt %0d stall %b exp 2/0", ld_count, stall); end
    for (int i = 0; i < 4; i++) begin
      fetch_req = 1'b1; A = addrs[i];
      q.push_back(model0(A));
      tick();
      n_cmp++;
      if (rd_valid !== 1'b1) begin
        n_bad++; $display("FAIL reload_valid[%0d] got %b exp 1", i, rd_valid);
      end else begin
        e = q.pop_front();
        if (RD !== e.rd || fault !== e.flt) begin
          n_bad++; $display("FAIL reload_fetch[%0d] got %h/%b exp %h/%b", i, RD, fault, e.rd, e.flt); end
      end
    end
    fetch_req = 1'b0;
    q.delete();
  endtask

  task automatic test_overflow;
    exp_t e;
    logic [31:0] a;
    int p;
    b_ld_start = 1'b1;
    tick();
    b_ld_start = 1'b0;
    n_cmp++; if (b_ld_ready !== 1'b1) begin n_bad++; $display("FAIL ovf_ready got %b exp 1", b_ld_ready); end
    p = 0;
    for (int i = 0; i < 6; i++) begin
      b_ld_valid = 1'b1; b_ld_data = 32'h1000_0000 + i; b_ld_last = (i == 5);
      if (p < 4) begin m4[p] = b_ld_data; p++; end
      tick();
    end
    b_ld_valid = 1'b0; b_ld_last = 1'b0;
    n_cmp++; if (b_ld_count !== 3'd4 || b_ld_err !== 1'b1 || b_stall !== 1'b0) begin
      n_bad++; $display("FAIL ovf_state got cnt %0d err %b stall %b exp 4/1/0", b_ld_count, b_ld_err, b_stall); end
    for (int i = 0; i < 5; i++) begin
      a = 32'(i * 4);
      b_fetch_req = 1'b1; b_A = a;
      if (a < 32'd16) begin e.rd = m4[a[3:2]]; e.flt = 1'b0; end
      else begin e.rd = NOP; e.flt = 1'b1; end
      q.push_back(e);
      tick();
      n_cmp++;
      if (b_rd_valid !== 1'b1) begin
        n_bad++; $display("FAIL ovf_valid[%0d] got %b exp 1", i, b_rd_valid);
      end else begin
        e = q.pop_front();
        if (b_RD !== e.rd || b_fault !== e.flt) begin
          n_bad++; $display("FAIL ovf_fetch[%0d] got %h/%b exp %h/%b", i, b_RD, b_fault, e.rd, e.flt); end
      end
    end
    b_fetch_req = 1'b0;
    q.delete();
  endtask

  task automatic test_reset_mid_load;
    exp_t e;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_data = 32'h00100093 + 32'(i) * 32'h0010_0080;
      m0[i] = ld_data;
      tick();
    end
    ld_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_cmp++; if (stall !== 1'b1 || ld_count !== 10'd0 || ld_ready !== 1'b0 || RD !== NOP) begin
      n_bad++; $display("FAIL midload_reset got stall %b cnt %0d rdy %b RD %h exp 1/0/0/%h", stall, ld_count, ld_ready, RD, NOP); end
    go = 1'b1;
    tick();
    go = 1'b0;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL go_run got stall %b exp 0", stall); end
    fetch_req = 1'b1; A = 32'd4; q.push_back(model0(A));
    tick();
    A = 32'd0; q.push_back(model0(A));
    n_cmp++;
    if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL midload_valid0 got %b exp 1", rd_valid); end
    else begin
      e = q.pop_front();
      if (RD !== e.rd || fault !== e.flt) begin n_bad++; $display("FAIL midload_fetch4 got %h exp %h", RD, e.rd); end
    end
    tick();
    fetch_req = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL midload_valid1 got %b exp 1", rd_valid); end
    else begin
      e = q.pop_front();
      if (RD !== e.rd || fault !== e.flt) begin n_bad++; $display("FAIL midload_fetch0 got %h exp %h", RD, e.rd); end
    end
    q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    ld_start = 0; ld_valid = 0; ld_last = 0; go = 0; fetch_req = 0; ld_data = 0; A = 0;
    b_ld_start = 0; b_ld_valid = 0; b_ld_last = 0; b_go = 0; b_fetch_req = 0; b_ld_data = 0; b_A = 0;
    for (int i = 0; i < 512; i++) m0[i] = NOP;
    for (int i = 0; i < 4; i++) m4[i] = NOP;
    w[0] = 32'h00A18293; w[1] = 32'h40C88133; w[2] = 32'h015E1D33; w[3] = 32'h00E0AA33;
    #3;
    test_reset();
    test_load_fetch();
    test_faults();
    test_gaps();
    test_overflow();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
